// File: rtl/lsu_queue_if.sv
// Pipeline, memory and writeback signals of the lsu_queue load/store unit.
// Optional `misalign` signal exists only when LSU_MISALIGN_CHK_EN is defined.
interface lsu_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  // execute-stage request
  logic              lsinstr;
  logic [ADDR_W-1:0] ADDR_IN;
  logic [DATA_W-1:0] ls_mux;
  logic              ls_mux_sel;
  logic [1:0]        ls_size;
  logic              ls_unsigned;
  logic              lsu_full;

  // memory port
  logic              proc_req;
  logic [ADDR_W-1:0] ADDR_OUT;
  logic              we;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] data_reg;
  logic              mem_rdy;
  logic              valid;
  logic [DATA_W-1:0] Rdata;

  // writeback
  logic [DATA_W-1:0] write_out;
  logic              wen;
  logic              store_ok;
`ifdef LSU_MISALIGN_CHK_EN
  logic              misalign;
`endif

  modport slave (
    input  lsinstr, ADDR_IN, ls_mux, ls_mux_sel, ls_size, ls_unsigned,
    input  mem_rdy, valid, Rdata,
    output lsu_full, proc_req, ADDR_OUT, we, be, data_reg,
    output write_out, wen, store_ok
`ifdef LSU_MISALIGN_CHK_EN
    , output misalign
`endif
  );

  modport master (
    output lsinstr, ADDR_IN, ls_mux, ls_mux_sel, ls_size, ls_unsigned,
    output mem_rdy, valid, Rdata,
    input  lsu_full, proc_req, ADDR_OUT, we, be, data_reg,
    input  write_out, wen, store_ok
`ifdef LSU_MISALIGN_CHK_EN
    , input misalign
`endif
  );
endinterface

// File: rtl/lsu_queue.sv
// In-order load/store queue issuing one memory request at a time.
// Define LSU_MISALIGN_CHK_EN to drop misaligned entries with a `misalign` pulse.
module lsu_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  lsu_queue_if.slave  bus
);
  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);
  localparam int PW  = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t r_state;

  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic              r_q_st   [DEPTH];
  logic [1:0]        r_q_size [DEPTH];
  logic              r_q_uns  [DEPTH];

  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;

  logic              r_proc_req, r_we, r_wen, r_store_ok;
  logic [ADDR_W-1:0] r_addr_out;
  logic [NB-1:0]     r_be;
  logic [DATA_W-1:0] r_data_reg, r_write_out;

  // fields of the entry currently being serviced, kept for response decode
  logic              r_cur_st, r_cur_uns;
  logic [1:0]        r_cur_size;
  logic [OFS-1:0]    r_cur_ofs;
`ifdef LSU_MISALIGN_CHK_EN
  logic              r_cur_mis, r_misalign, w_fill_mis;
`endif

  logic              w_full, w_accept, w_pop, w_enter_req, w_use_in;
  logic [PW:0]       w_cnt_after;
  logic [PW-1:0]     w_rd_ptr;
  logic [ADDR_W-1:0] w_fill_addr;
  logic [DATA_W-1:0] w_fill_data, w_rep, w_shift, w_lmask, w_load_res;
  logic              w_fill_st, w_fill_uns, w_sbit;
  logic [1:0]        w_fill_raw, w_fill_size;
  logic [3:0]        w_nbytes, w_ofs4, w_lim;
  logic [NB-1:0]     w_be;

  assign w_full   = (r_count == (PW+1)'(DEPTH));
  assign w_accept = bus.lsinstr && !w_full;

  always_comb begin
    w_pop = (r_state == WAIT) && bus.valid;
`ifdef LSU_MISALIGN_CHK_EN
    if (r_state == REQ && r_cur_mis)
      w_pop = 1'b1;
`endif
  end

  assign w_cnt_after = r_count + (PW+1)'(w_accept) - (PW+1)'(w_pop);
  assign w_enter_req = ((r_state == IDLE) && (r_count != '0)) ||
                       (w_pop && (w_cnt_after != '0));

  // After a pop the next entry is head+1; if the queue held only the popped
  // entry, the next one is the request being accepted on this very edge.
  assign w_rd_ptr = (r_state == IDLE) ? r_head : r_head + 1'b1;
  assign w_use_in = (r_state != IDLE) && (r_count == (PW+1)'(1));

  always_comb begin
    if (w_use_in) begin
      w_fill_addr = bus.ADDR_IN;
      w_fill_data = bus.ls_mux;
      w_fill_st   = bus.ls_mux_sel;
      w_fill_raw  = bus.ls_size;
      w_fill_uns  = bus.ls_unsigned;
    end else begin
      w_fill_addr = r_q_addr[w_rd_ptr];
      w_fill_data = r_q_data[w_rd_ptr];
      w_fill_st   = r_q_st[w_rd_ptr];
      w_fill_raw  = r_q_size[w_rd_ptr];
      w_fill_uns  = r_q_uns[w_rd_ptr];
    end
  end

  // doubleword on a 32-bit port degrades to word
  assign w_fill_size = (DATA_W == 32 && w_fill_raw == 2'b11) ? 2'b10 : w_fill_raw;

  always_comb begin
    case (w_fill_size)
      2'b00:   w_nbytes = 4'd1;
      2'b01:   w_nbytes = 4'd2;
      2'b10:   w_nbytes = 4'd4;
      default: w_nbytes = 4'd8;
    endcase
  end

  assign w_ofs4 = 4'(w_fill_addr[OFS-1:0]);
  assign w_lim  = w_ofs4 + w_nbytes;

  // Per-lane enable and store-data replication; lanes past NB simply vanish.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign w_be[gi] = (4'(gi) >= w_ofs4) && (4'(gi) < w_lim);
      assign w_rep[8*gi +: 8] =
        (w_fill_size == 2'b00) ? w_fill_data[7:0] :
        (w_fill_size == 2'b01) ? w_fill_data[8*(gi%2) +: 8] :
        (w_fill_size == 2'b10) ? w_fill_data[8*(gi%4) +: 8] :
                                 w_fill_data[8*(gi%8) +: 8];
    end
  endgenerate

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    case (w_fill_size)
      2'b01:   w_fill_mis = w_fill_addr[0];
      2'b10:   w_fill_mis = |w_fill_addr[1:0];
      2'b11:   w_fill_mis = |w_fill_addr[2:0];
      default: w_fill_mis = 1'b0;
    endcase
  end
`endif

  assign w_shift = bus.Rdata >> {r_cur_ofs, 3'b000};

  always_comb begin
    case (r_cur_size)
      2'b00: begin
        w_lmask = DATA_W'(8'hFF);
        w_sbit  = w_shift[7];
      end
      2'b01: begin
        w_lmask = DATA_W'(16'hFFFF);
        w_sbit  = w_shift[15];
      end
      2'b10: begin
        w_lmask = DATA_W'(32'hFFFF_FFFF);
        w_sbit  = w_shift[31];
      end
      default: begin
        w_lmask = '1;
        w_sbit  = w_shift[DATA_W-1];
      end
    endcase
    w_load_res = (w_shift & w_lmask) | ((!r_cur_uns && w_sbit) ? ~w_lmask : '0);
  end

  // Queue storage: no reset, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_addr[r_tail] <= bus.ADDR_IN;
      r_q_data[r_tail] <= bus.ls_mux;
      r_q_st[r_tail]   <= bus.ls_mux_sel;
      r_q_size[r_tail] <= bus.ls_size;
      r_q_uns[r_tail]  <= bus.ls_unsigned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_proc_req  <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr_out  <= '0;
      r_data_reg  <= '0;
      r_write_out <= '0;
      r_wen       <= 1'b0;
      r_store_ok  <= 1'b0;
      r_cur_st    <= 1'b0;
      r_cur_uns   <= 1'b0;
      r_cur_size  <= 2'b00;
      r_cur_ofs   <= '0;
`ifdef LSU_MISALIGN_CHK_EN
      r_cur_mis   <= 1'b0;
      r_misalign  <= 1'b0;
`endif
    end else begin
      r_wen      <= 1'b0;
      r_store_ok <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
      r_misalign <= 1'b0;
`endif
      if (w_accept) r_tail <= r_tail + 1'b1;
      if (w_pop)    r_head <= r_head + 1'b1;
      r_count <= w_cnt_after;

      case (r_state)
        IDLE: begin
          if (r_count != '0) r_state <= REQ;
        end
        REQ: begin
`ifdef LSU_MISALIGN_CHK_EN
          if (r_cur_mis) begin
            r_misalign <= 1'b1;
            r_state    <= (w_cnt_after != '0) ? REQ : IDLE;
          end else
`endif
          if (bus.mem_rdy) begin
            r_state    <= WAIT;
            r_proc_req <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.valid) begin
            if (r_cur_st) begin
              r_store_ok <= 1'b1;
            end else begin
              r_wen       <= 1'b1;
              r_write_out <= w_load_res;
            end
            r_state <= (w_cnt_after != '0) ? REQ : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_enter_req) begin
        r_addr_out <= w_fill_addr & ~ADDR_W'(NB - 1);
        r_we       <= w_fill_st;
        r_be       <= w_be;
        r_data_reg <= w_rep;
        r_cur_st   <= w_fill_st;
        r_cur_uns  <= w_fill_uns;
        r_cur_size <= w_fill_size;
        r_cur_ofs  <= w_fill_addr[OFS-1:0];
`ifdef LSU_MISALIGN_CHK_EN
        r_cur_mis  <= w_fill_mis;
        r_proc_req <= !w_fill_mis;
`else
        r_proc_req <= 1'b1;
`endif
      end
    end
  end

  assign bus.lsu_full  = w_full;
  assign bus.proc_req  = r_proc_req;
  assign bus.ADDR_OUT  = r_addr_out;
  assign bus.we        = r_we;
  assign bus.be        = r_be;
  assign bus.data_reg  = r_data_reg;
  assign bus.write_out = r_write_out;
  assign bus.wen       = r_wen;
  assign bus.store_ok  = r_store_ok;
`ifdef LSU_MISALIGN_CHK_EN
  assign bus.misalign  = r_misalign;
`endif

endmodule

// File: tb/tb_lsu_queue.sv
// Directed bench for lsu_queue (DATA_W=32, DEPTH=4): inputs driven and
// outputs sampled on the falling edge.
module tb_lsu_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_queue_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  lsu_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] f_addr [4] = '{32'h100, 32'h106, 32'h109, 32'h10C};
  logic [1:0]  f_size [4] = '{2'b10, 2'b01, 2'b00, 2'b01};
  logic        f_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] f_aout [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic [3:0]  f_be   [4] = '{4'hF, 4'hC, 4'h2, 4'h3};
  logic [31:0] f_rd   [4] = '{32'hA5A5_0001, 32'h8001_1234, 32'h0000_7F00, 32'h0000_F00D};
  logic [31:0] f_res  [4] = '{32'hA5A5_0001, 32'h0000_8001, 32'h0000_007F, 32'hFFFF_F00D};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] data,
                      input logic st, input logic [1:0] size, input logic uns);
    bus.lsinstr     = 1'b1;
    bus.ADDR_IN     = addr;
    bus.ls_mux      = data;
    bus.ls_mux_sel  = st;
    bus.ls_size     = size;
    bus.ls_unsigned = uns;
    $display("[TB] request addr=%h data=%h store=%0d size=%0d unsigned=%0d",
             addr, data, st, size, uns);
  endtask

  initial begin
    bus.lsinstr = 1'b0; bus.ADDR_IN = '0; bus.ls_mux = '0; bus.ls_mux_sel = 1'b0;
    bus.ls_size = 2'b00; bus.ls_unsigned = 1'b0;
    bus.mem_rdy = 1'b0; bus.valid = 1'b0; bus.Rdata = '0;

    // reset state
    tick(); tick();
    chk("rst_proc_req", bus.proc_req, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_be", bus.be, 0);
    chk("rst_addr_out", bus.ADDR_OUT, 0);
    chk("rst_data_reg", bus.data_reg, 0);
    chk("rst_write_out", bus.write_out, 0);
    chk("rst_wen", bus.wen, 0);
    chk("rst_store_ok", bus.store_ok, 0);
    chk("rst_lsu_full", bus.lsu_full, 0);
    rst = 1'b0;

    // signed byte load from the top lane
    push(32'h1003, 32'h0, 1'b0, 2'b00, 1'b0);
    tick(); bus.lsinstr = 1'b0;
    chk("lb_req_latency", bus.proc_req, 0);
    tick();
    chk("lb_proc_req", bus.proc_req, 1);
    chk("lb_addr_out", bus.ADDR_OUT, 32'h1000);
    chk("lb_be", bus.be, 4'h8);
    chk("lb_we", bus.we, 0);
    bus.mem_rdy = 1'b1; tick(); bus.mem_rdy = 1'b0;
    chk("lb_wait_req_low", bus.proc_req, 0);
    bus.valid = 1'b1; bus.Rdata = 32'h80FF_FFFF; tick(); bus.valid = 1'b0;
    chk("lb_wen", bus.wen, 1);
    chk("lb_write_out", bus.write_out, 32'hFFFF_FF80);
    tick();
    chk("lb_wen_pulse", bus.wen, 0);
    chk("lb_write_out_hold", bus.write_out, 32'hFFFF_FF80);

    // half store
    push(32'h2002, 32'h0000_BEEF, 1'b1, 2'b01, 1'b0);
    tick(); bus.lsinstr = 1'b0; tick();
    chk("sh_proc_req", bus.proc_req, 1);
    chk("sh_we", bus.we, 1);
    chk("sh_be", bus.be, 4'hC);
    chk("sh_data_reg", bus.data_reg, 32'hBEEF_BEEF);
    chk("sh_addr_out", bus.ADDR_OUT, 32'h2000);
    bus.mem_rdy = 1'b1; tick(); bus.mem_rdy = 1'b0;
    bus.valid = 1'b1; tick(); bus.valid = 1'b0;
    chk("sh_store_ok", bus.store_ok, 1);
    chk("sh_no_wen", bus.wen, 0);
    tick();
    chk("sh_store_ok_pulse", bus.store_ok, 0);

    // accept and pop on the same edge with a single entry queued
    push(32'h7000, 32'h0, 1'b0, 2'b10, 1'b0);
    tick(); bus.lsinstr = 1'b0; tick();
    bus.mem_rdy = 1'b1; tick(); bus.mem_rdy = 1'b0;
    bus.valid = 1'b1; bus.Rdata = 32'h1111_1111;
    push(32'h7008, 32'hCAFE_F00D, 1'b1, 2'b10, 1'b0);
    tick(); bus.lsinstr = 1'b0; bus.valid = 1'b0;
    chk("sim_wen", bus.wen, 1);
    chk("sim_write_out", bus.write_out, 32'h1111_1111);
    chk("sim_next_req", bus.proc_req, 1);
    chk("sim_next_addr", bus.ADDR_OUT, 32'h7008);
    chk("sim_next_we", bus.we, 1);
    chk("sim_next_data", bus.data_reg, 32'hCAFE_F00D);
    chk("sim_next_be", bus.be, 4'hF);
    bus.mem_rdy = 1'b1; tick(); bus.mem_rdy = 1'b0;
    bus.valid = 1'b1; tick(); bus.valid = 1'b0;
    chk("sim_store_ok", bus.store_ok, 1);
    tick();

    // fill to DEPTH with memory stalled, reject the fifth, drain in order
    for (int i = 0; i < 4; i++) begin
      push(f_addr[i], 32'h0, 1'b0, f_size[i], f_uns[i]);
      tick();
      if (i == 2) chk("fill_not_full_3", bus.lsu_full, 0);
    end
    chk("fill_full_4", bus.lsu_full, 1);
    push(32'h110, 32'h0, 1'b0, 2'b10, 1'b0);
    tick(); bus.lsinstr = 1'b0;
    chk("fill_full_reject", bus.lsu_full, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_req", i), bus.proc_req, 1);
      chk($sformatf("drain%0d_addr", i), bus.ADDR_OUT, f_aout[i]);
      chk($sformatf("drain%0d_be", i), bus.be, f_be[i]);
      bus.mem_rdy = 1'b1; tick(); bus.mem_rdy = 1'b0;
      bus.valid = 1'b1; bus.Rdata = f_rd[i]; tick(); bus.valid = 1'b0;
      chk($sformatf("drain%0d_wen", i), bus.wen, 1);
      chk($sformatf("drain%0d_data", i), bus.write_out, f_res[i]);
      if (i == 0) chk("drain_unfull", bus.lsu_full, 0);
    end
    tick();
    chk("drain_empty_req", bus.proc_req, 0);

    // stall: mem_rdy low for 3 cycles, stray valid in REQ ignored
    push(32'h5004, 32'h0, 1'b0, 2'b10, 1'b0);
    tick(); bus.lsinstr = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1; bus.Rdata = 32'hFFFF_FFFF; tick();
      chk($sformatf("stall%0d_req", i), bus.proc_req, 1);
      chk($sformatf("stall%0d_addr", i), bus.ADDR_OUT, 32'h5004);
      chk($sformatf("stall%0d_no_wen", i), bus.wen, 0);
    end
    bus.valid = 1'b0; bus.mem_rdy = 1'b1; tick(); bus.mem_rdy = 1'b0;
    bus.valid = 1'b1; bus.Rdata = 32'h1234_5678; tick(); bus.valid = 1'b0;
    chk("stall_wen", bus.wen, 1);
    chk("stall_write_out", bus.write_out, 32'h1234_5678);
    tick();

    // reset while waiting with 3 entries queued
    push(32'h6000, 32'h0, 1'b0, 2'b10, 1'b0); tick();
    push(32'h6004, 32'h0, 1'b0, 2'b10, 1'b0); tick();
    push(32'h6008, 32'h0, 1'b0, 2'b10, 1'b0); tick();
    bus.lsinstr = 1'b0;
    chk("rw_req", bus.proc_req, 1);
    bus.mem_rdy = 1'b1; tick(); bus.mem_rdy = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rw_proc_req", bus.proc_req, 0);
    chk("rw_lsu_full", bus.lsu_full, 0);
    chk("rw_write_out", bus.write_out, 0);
    bus.valid = 1'b1; bus.Rdata = 32'hDEAD_BEEF; tick(); bus.valid = 1'b0;
    chk("rw_late_valid_wen", bus.wen, 0);
    tick();
    chk("rw_flushed_req", bus.proc_req, 0);
    tick();
    chk("rw_flushed_req2", bus.proc_req, 0);

`ifdef LSU_MISALIGN_CHK_EN
    begin
      int mis_cnt;
      mis_cnt = 0;
      push(32'h3002, 32'h0, 1'b0, 2'b10, 1'b0);
      tick(); bus.lsinstr = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (bus.misalign === 1'b1) mis_cnt++;
        chk($sformatf("mis%0d_no_req", i), bus.proc_req, 0);
        chk($sformatf("mis%0d_no_wen", i), bus.wen, 0);
        tick();
      end
      chk("mis_pulse_count", 64'(mis_cnt), 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
